// File: rtl/event_publisher.sv
// Publish/subscribe hub: one publication at a time, fanned out to every subscriber
// registered for its topic, with an independent valid/ready handshake per subscriber.

module event_publisher_lane #(
    parameter int NUM_TOPICS = 8,
    parameter int TW         = $clog2(NUM_TOPICS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          reg_wr,
    input  logic [TW-1:0] reg_topic,
    input  logic          reg_en,
    input  logic [TW-1:0] pub_topic,
    input  logic          load,
    input  logic          evt_ready,
    output logic          hit,
    output logic          pending
);
    // This subscriber's column of the subscription table
    logic [NUM_TOPICS-1:0] subs;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)         subs <= '0;
        else if (reg_wr) subs[reg_topic] <= reg_en;
    end

    // Read before any same-cycle write lands, so a registration never races an accept
    assign hit = subs[pub_topic];

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                       pending <= 1'b0;
        else if (load)                 pending <= hit;
        else if (pending && evt_ready) pending <= 1'b0;
    end
endmodule

module event_publisher #(
    parameter int NUM_SUBS   = 4,
    parameter int NUM_TOPICS = 8,
    parameter int DATA_W     = 32,
    localparam int TW        = $clog2(NUM_TOPICS),
    localparam int SW        = (NUM_SUBS > 1) ? $clog2(NUM_SUBS) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                pub_valid,
    output logic                pub_ready,
    input  logic [TW-1:0]       pub_topic,
    input  logic [DATA_W-1:0]   pub_data,
    input  logic                reg_valid,
    input  logic [SW-1:0]       reg_sub,
    input  logic [TW-1:0]       reg_topic,
    input  logic                reg_en,
    output logic [NUM_SUBS-1:0] evt_valid,
    input  logic [NUM_SUBS-1:0] evt_ready,
    output logic [TW-1:0]       evt_topic,
    output logic [DATA_W-1:0]   evt_data,
    output logic                busy,
    output logic [15:0]         nosub_cnt
);
    typedef enum logic {IDLE, DELIVER} state_t;

    state_t state, state_nx;
    logic [NUM_SUBS-1:0] hit, pending;
    logic accept;

    assign accept = (state == IDLE) && pub_valid;

    // Out-of-range reg_sub matches no lane and is therefore dropped
    for (genvar i = 0; i < NUM_SUBS; i++) begin : g_lane
        event_publisher_lane #(.NUM_TOPICS(NUM_TOPICS), .TW(TW)) u_lane (
            .clk       (clk),
            .rst       (rst),
            .reg_wr    (reg_valid && (reg_sub == SW'(i))),
            .reg_topic (reg_topic),
            .reg_en    (reg_en),
            .pub_topic (pub_topic),
            .load      (accept),
            .evt_ready (evt_ready[i]),
            .hit       (hit[i]),
            .pending   (pending[i])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept && (hit != '0)) state_nx = DELIVER;
            DELIVER: if ((pending & ~evt_ready) == '0) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            evt_topic <= '0;
            evt_data  <= '0;
            nosub_cnt <= '0;
        end else if (accept) begin
            evt_topic <= pub_topic;
            evt_data  <= pub_data;
            if (hit == '0 && nosub_cnt != 16'hFFFF) nosub_cnt <= nosub_cnt + 16'd1;
        end
    end

    assign evt_valid = pending;
    assign busy      = (state == DELIVER);
    assign pub_ready = (state == IDLE) && !rst;
endmodule

// File: tb/tb_event_publisher.sv
// Directed bench for event_publisher: per-subscriber scoreboard queues checked by an
// independent handshake monitor, plus inline checks of control outputs.

module tb_event_publisher;
    localparam int NS = 4;
    localparam int NT = 8;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          pub_valid;
    logic          pub_ready;
    logic [2:0]    pub_topic;
    logic [DW-1:0] pub_data;
    logic          reg_valid;
    logic [1:0]    reg_sub;
    logic [2:0]    reg_topic;
    logic          reg_en;
    logic [NS-1:0] evt_valid;
    logic [NS-1:0] evt_ready;
    logic [2:0]    evt_topic;
    logic [DW-1:0] evt_data;
    logic          busy;
    logic [15:0]   nosub_cnt;

    int tests = 0;
    int fails = 0;
    logic [34:0] expq[NS][$];

    event_publisher #(.NUM_SUBS(NS), .NUM_TOPICS(NT), .DATA_W(DW)) dut (
        .clk(clk), .rst(rst),
        .pub_valid(pub_valid), .pub_ready(pub_ready), .pub_topic(pub_topic), .pub_data(pub_data),
        .reg_valid(reg_valid), .reg_sub(reg_sub), .reg_topic(reg_topic), .reg_en(reg_en),
        .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_topic(evt_topic), .evt_data(evt_data),
        .busy(busy), .nosub_cnt(nosub_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reg_cmd(input int sub, input int topic, input logic en);
        reg_valid = 1'b1;
        reg_sub   = 2'(sub);
        reg_topic = 3'(topic);
        reg_en    = en;
        tick();
        reg_valid = 1'b0;
    endtask

    // Issues one publication from IDLE; subs lists the hand-computed recipients
    task automatic publish(input int topic, input logic [DW-1:0] data, input logic [NS-1:0] subs);
        pub_valid = 1'b1;
        pub_topic = 3'(topic);
        pub_data  = data;
        for (int i = 0; i < NS; i++)
            if (subs[i]) expq[i].push_back({3'(topic), data});
        tick();
        pub_valid = 1'b0;
    endtask

    // Monitor: every completed handshake must match the head of that subscriber's queue
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                for (int i = 0; i < NS; i++) begin
                    if (evt_valid[i] && evt_ready[i]) begin
                        tests++;
                        if (expq[i].size() == 0) begin
                            fails++;
                            $display("FAIL sub%0d_unexpected: got topic %0h data %0h expected none",
                                     i, evt_topic, evt_data);
                        end else begin
                            logic [34:0] e;
                            e = expq[i].pop_front();
                            if ({evt_topic, evt_data} !== e) begin
                                fails++;
                                $display("FAIL sub%0d_event: got %0h expected %0h", i, {evt_topic, evt_data}, e);
                            end
                        end
                    end
                end
            end
        end
    end

    initial begin
        rst = 1'b1; pub_valid = 1'b0; pub_topic = '0; pub_data = '0;
        reg_valid = 1'b0; reg_sub = '0; reg_topic = '0; reg_en = 1'b0; evt_ready = '0;
        #2;
        chk("rst_pub_ready", pub_ready, 0);
        chk("rst_evt_valid", evt_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_nosub", nosub_cnt, 0);
        chk("rst_evt_data", evt_data, 0);
        tick(); tick();
        rst = 1'b0;
        #1;

        // No subscribers
        chk("idle_pub_ready", pub_ready, 1);
        publish(3, 32'hA5A5A5A5, 4'b0000);
        chk("nosub_cnt_1", nosub_cnt, 1);
        chk("nosub_evt_valid", evt_valid, 0);
        chk("nosub_busy", busy, 0);
        chk("nosub_pub_ready", pub_ready, 1);

        // Basic fan-out
        reg_cmd(0, 1, 1'b1);
        reg_cmd(2, 1, 1'b1);
        evt_ready = 4'hF;
        publish(1, 32'h12345678, 4'b0101);
        chk("fan_evt_valid", evt_valid, 4'b0101);
        chk("fan_evt_data", evt_data, 32'h12345678);
        chk("fan_pub_ready_low", pub_ready, 0);
        tick();
        chk("fan_evt_valid_done", evt_valid, 0);
        chk("fan_pub_ready_back", pub_ready, 1);

        // Staggered ready; sub 2 raises ready without being subscribed
        evt_ready = 4'h0;
        reg_cmd(0, 5, 1'b1);
        reg_cmd(1, 5, 1'b1);
        reg_cmd(3, 5, 1'b1);
        publish(5, 32'hCAFEF00D, 4'b1011);
        evt_ready = 4'b0101;
        chk("stag_p1", evt_valid, 4'b1011);
        tick(); evt_ready = 4'b0000;
        chk("stag_p2", evt_valid, 4'b1010);
        tick();
        chk("stag_p3", evt_valid, 4'b1010);
        tick(); evt_ready = 4'b1000;
        chk("stag_p4", evt_valid, 4'b1010);
        tick(); evt_ready = 4'b0000;
        chk("stag_p5", evt_valid, 4'b0010);
        chk("stag_topic_stable", evt_topic, 5);
        tick(); evt_ready = 4'b0010;
        chk("stag_p6", evt_valid, 4'b0010);
        chk("stag_busy_p6", busy, 1);
        tick(); evt_ready = 4'b0000;
        chk("stag_p7_valid", evt_valid, 0);
        chk("stag_p7_busy", busy, 0);

        // Snapshot isolation
        reg_cmd(1, 2, 1'b1);
        publish(2, 32'h22220001, 4'b0010);
        reg_cmd(1, 2, 1'b0);
        reg_cmd(0, 2, 1'b1);
        chk("snap_inflight", evt_valid, 4'b0010);
        evt_ready = 4'b0010;
        tick(); evt_ready = 4'b0000;
        chk("snap_done", busy, 0);
        publish(2, 32'h22220002, 4'b0001);
        chk("snap_next", evt_valid, 4'b0001);
        evt_ready = 4'hF;
        tick();

        // Same-cycle registration and accept
        reg_valid = 1'b1; reg_sub = 2'd3; reg_topic = 3'd0; reg_en = 1'b1;
        pub_valid = 1'b1; pub_topic = 3'd0; pub_data = 32'h00000BAD;
        tick();
        reg_valid = 1'b0; pub_valid = 1'b0;
        chk("same_nosub", nosub_cnt, 2);
        chk("same_evt_valid", evt_valid, 0);
        publish(0, 32'h0000600D, 4'b1000);
        chk("same_next", evt_valid, 4'b1000);
        tick();

        // Saturation: back-to-back unsubscribed publications, one per cycle
        pub_valid = 1'b1; pub_topic = 3'd6; pub_data = 32'h0;
        for (int i = 0; i < 65533; i++) tick();
        chk("sat_reach", nosub_cnt, 16'hFFFF);
        chk("sat_pub_ready", pub_ready, 1);
        tick();
        pub_valid = 1'b0;
        chk("sat_hold", nosub_cnt, 16'hFFFF);

        // Async reset mid-delivery
        evt_ready = 4'h0;
        pub_valid = 1'b1; pub_topic = 3'd1; pub_data = 32'hDEADBEEF;
        tick();
        pub_valid = 1'b0;
        chk("arst_pre_valid", evt_valid, 4'b0101);
        chk("arst_pre_busy", busy, 1);
        #2 rst = 1'b1;
        #1;
        chk("arst_valid", evt_valid, 0);
        chk("arst_busy", busy, 0);
        chk("arst_pub_ready", pub_ready, 0);
        chk("arst_nosub", nosub_cnt, 0);
        tick();
        rst = 1'b0;
        #1;
        evt_ready = 4'hF;
        publish(1, 32'h11111111, 4'b0000);
        chk("arst_table_cleared", nosub_cnt, 1);
        chk("arst_no_event", evt_valid, 0);
        tick();

        for (int i = 0; i < NS; i++) chk($sformatf("sub%0d_queue_empty", i), expq[i].size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
